// File: rtl/prei_md_pingpong_ctrl.sv
// Ping-pong bank controller between the pre-intra mode engine (writer)
// and the post-intra consumer (reader) of per-CTU mode sets.
module prei_md_pingpong_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             frame_start_i,
    input  logic             prei_req_i,
    output logic             prei_start_o,
    input  logic             prei_done_i,
    output logic             sel_mod_2_o,
    output logic             posi_valid_o,
    input  logic             posi_done_i,
    output logic             wr_full_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] swap_cnt_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             wr_full;
    logic             wr_full_nxt;
    logic             sel;
    logic             sel_nxt;
    logic             pv;
    logic             pv_nxt;
    logic             err;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             swap;
    logic             prei_err;
    logic             posi_err;
    logic             ctu_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            wr_full <= 1'b0;
            sel     <= 1'b0;
            pv      <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            wr_full <= wr_full_nxt;
            sel     <= sel_nxt;
            pv      <= pv_nxt;
            err     <= err_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // A start is only launched from a registered empty write bank, so a
    // swap and the following start land in consecutive cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (prei_req_i && !wr_full) state_nxt = START;
            START:   state_nxt = RUN;
            RUN:     if (prei_done_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ctu_done = (state == RUN) && prei_done_i;
    assign swap     = wr_full && (!pv || posi_done_i);
    assign prei_err = prei_done_i && (state != RUN);
    assign posi_err = posi_done_i && !pv;

    always_comb begin
        wr_full_nxt = wr_full;
        sel_nxt     = sel;
        pv_nxt      = pv;
        err_nxt     = err;
        cnt_nxt     = cnt;
        if (swap) begin
            wr_full_nxt = 1'b0;
            sel_nxt     = ~sel;
            pv_nxt      = 1'b1;
            cnt_nxt     = cnt + CNT_W'(1);
        end else begin
            if (ctu_done)    wr_full_nxt = 1'b1;
            if (posi_done_i) pv_nxt      = 1'b0;
        end
        if (prei_err || posi_err) err_nxt = 1'b1;
        if (frame_start_i) begin
            cnt_nxt = '0;
            err_nxt = 1'b0;
        end
    end

    assign prei_start_o = (state == START);
    assign busy_o       = (state != IDLE);
    assign sel_mod_2_o  = sel;
    assign posi_valid_o = pv;
    assign wr_full_o    = wr_full;
    assign swap_cnt_o   = cnt;
    assign err_o        = err;

endmodule

// File: tb/tb_prei_md_pingpong_ctrl.sv
// Directed bench for the pre-intra ping-pong controller: a cycle table
// plus hand sequences for counter wrap and reset in the middle of a CTU.
module tb_prei_md_pingpong_ctrl;

    typedef struct packed {
        logic        fs;
        logic        req;
        logic        pd;
        logic        qd;
        logic        st;
        logic        sel;
        logic        pv;
        logic        wf;
        logic        busy;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        frame_start;
    logic        prei_req;
    logic        prei_done;
    logic        posi_done;
    logic        prei_start;
    logic        sel_mod_2;
    logic        posi_valid;
    logic        wr_full;
    logic        busy;
    logic [15:0] swap_cnt;
    logic        err;
    logic        w2_start;
    logic        w2_sel;
    logic        w2_pv;
    logic        w2_wf;
    logic        w2_busy;
    logic [1:0]  w2_cnt;
    logic        w2_err;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl [26];

    always #5 clk = ~clk;

    prei_md_pingpong_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .frame_start_i (frame_start),
        .prei_req_i    (prei_req),
        .prei_start_o  (prei_start),
        .prei_done_i   (prei_done),
        .sel_mod_2_o   (sel_mod_2),
        .posi_valid_o  (posi_valid),
        .posi_done_i   (posi_done),
        .wr_full_o     (wr_full),
        .busy_o        (busy),
        .swap_cnt_o    (swap_cnt),
        .err_o         (err)
    );

    prei_md_pingpong_ctrl #(.CNT_W(2)) dut_w2 (
        .clk           (clk),
        .rstn          (rstn),
        .frame_start_i (frame_start),
        .prei_req_i    (prei_req),
        .prei_start_o  (w2_start),
        .prei_done_i   (prei_done),
        .sel_mod_2_o   (w2_sel),
        .posi_valid_o  (w2_pv),
        .posi_done_i   (posi_done),
        .wr_full_o     (w2_wf),
        .busy_o        (w2_busy),
        .swap_cnt_o    (w2_cnt),
        .err_o         (w2_err)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic st,
                             input logic sl, input logic pv,
                             input logic wf, input logic bz,
                             input logic [15:0] cn, input logic er);
        check({tag, " start"}, 32'(prei_start), 32'(st));
        check({tag, " sel"}, 32'(sel_mod_2), 32'(sl));
        check({tag, " posi_valid"}, 32'(posi_valid), 32'(pv));
        check({tag, " wr_full"}, 32'(wr_full), 32'(wf));
        check({tag, " busy"}, 32'(busy), 32'(bz));
        check({tag, " swap_cnt"}, 32'(swap_cnt), 32'(cn));
        check({tag, " err"}, 32'(err), 32'(er));
        check({tag, " w2_cnt"}, 32'(w2_cnt), 32'(cn[1:0]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fs, input logic rq,
                         input logic pd, input logic qd);
        frame_start = fs;
        prei_req    = rq;
        prei_done   = pd;
        posi_done   = qd;
    endtask

    // One full CTU where the consumer releases its bank as soon as the
    // new one is complete, so each call produces exactly one swap.
    task automatic run_ctu(input int idx);
        int  n = 0;
        logic seen = 1'b0;
        drive(0, 1, 0, 0);
        while (!seen && n < 10) begin
            step();
            seen = prei_start;
            n++;
        end
        check($sformatf("ctu%0d start seen", idx), 32'(seen), 32'd1);
        drive(0, 0, 0, 0);
        step();
        drive(0, 0, 1, 0);
        step();
        check($sformatf("ctu%0d wr_full", idx), 32'(wr_full), 32'd1);
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           fs req pd qd | st sel pv wf bz cnt err
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
        tbl[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};

        rstn = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 16'd0, 0);
        rstn = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].fs, tbl[i].req, tbl[i].pd, tbl[i].qd);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].sel,
                      tbl[i].pv, tbl[i].wf, tbl[i].busy, tbl[i].cnt,
                      tbl[i].err);
        end
        drive(0, 0, 0, 0);

        // Five swaps: 16-bit counter reads 5, 2-bit counter wraps to 1.
        for (int k = 0; k < 5; k++) run_ctu(k);
        step();
        check("wrap cnt16", 32'(swap_cnt), 32'd5);
        check("wrap cnt2", 32'(w2_cnt), 32'd1);
        check("wrap sel", 32'(sel_mod_2), 32'd1);
        check("wrap err", 32'(err), 32'd0);

        // Reset in the middle of a CTU.
        drive(0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        check("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_all("midrun reset", 0, 0, 0, 0, 0, 16'd0, 0);
        check("midrun reset w2 busy", 32'(w2_busy), 32'd0);
        step();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post-reset idle%0d start", k),
                  32'(prei_start), 32'd0);
            check($sformatf("post-reset idle%0d busy", k),
                  32'(busy), 32'd0);
        end
        drive(0, 1, 0, 0);
        step();
        check("post-reset restart", 32'(prei_start), 32'd1);
        drive(0, 0, 0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
